arith_issue_seq: RTL and testbench

ARITH_ISSUE_SEQ -- requirements
Module: arith_issue_seq

---
 rtl/arith_issue_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_arith_issue_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_issue_seq.sv
// arith_issue_seq: buffers one command's FP16 elements, then replays them to the arithmetic pipeline.
// Latency: first beat the cycle after the last load beat; softmax replays after DRAIN_CYC idle cycles.
// Backpressure: cmd_ready only in IDLE, in_ready only in LOAD; output side has no backpressure.
// Optional: define ARITH_ISSUE_PERF_EN to enable the issued-beat counter on perf_cnt.
module arith_issue_seq #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_psum,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] out_psum,
  output logic [1:0]  out_mode,
  output logic        done,
  output logic        err,
  output logic [31:0] perf_cnt
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DCW   = $clog2(DRAIN_CYC + 1) + 1;

  localparam logic [1:0] OP_SOFTMAX = 2'd0;
  localparam logic [1:0] OP_GELU    = 2'd1;
  localparam logic [1:0] OP_AGG     = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  localparam logic [1:0] MODE_EXP  = 2'd0;
  localparam logic [1:0] MODE_DIV  = 2'd1;
  localparam logic [1:0] MODE_GELU = 2'd2;
  localparam logic [1:0] MODE_AGG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PASS0 = 3'd2,
    S_DRAIN = 3'd3,
    S_PASS1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [PTR_W-1:0]   len_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [DCW-1:0]     drain_q;
  logic               cmd_ready_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        out_data_q;
  logic [15:0]        out_psum_q;
  logic [1:0]         out_mode_q;
  logic               done_q;
  logic               err_q;

  // Element store: {data, psum}; survives across commands, only pointers reset.
  logic [31:0]        mem_q [DEPTH];

  logic               cmd_illegal;
  logic               load_last;
  logic               pass_end;
  logic [1:0]         pass0_mode;
  logic [AW-1:0]      iss_idx;
  logic [31:0]        iss_word;
  logic [15:0]        pass0_psum;

  // Command legality, load completion and pass completion decode.
  always_comb begin
    cmd_illegal = (cmd_op == OP_RSVD) || (cmd_len == 4'd0) || (32'(cmd_len) > DEPTH);
    load_last   = in_valid && ((wr_ptr_q + PTR_W'(1)) == len_q);
    pass_end    = (rd_ptr_q == len_q);
    case (op_q)
      OP_SOFTMAX: pass0_mode = MODE_EXP;
      OP_GELU:    pass0_mode = MODE_GELU;
      OP_AGG:     pass0_mode = MODE_AGG;
      default:    pass0_mode = MODE_EXP;
    endcase
  end

  // Element selected for the beat registered at the next edge. Index 0 is used when a
  // pass is being started; a len=1 command forwards the element being written right now.
  always_comb begin
    iss_idx = '0;
    if ((state_q == S_PASS0 || state_q == S_PASS1) && !pass_end) begin
      iss_idx = rd_ptr_q[AW-1:0];
    end
    iss_word = mem_q[iss_idx];
    if (state_q == S_LOAD && wr_ptr_q == '0) begin
      iss_word = {in_data, in_psum};
    end
    pass0_psum = (op_q == OP_AGG) ? iss_word[15:0] : 16'd0;
  end

  // Buffer write on each accepted element.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_data, in_psum};
    end
  end

  // Sequencer FSM with registered handshake and issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SOFTMAX;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drain_q     <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_psum_q  <= '0;
      out_mode_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_illegal) begin
              err_q <= 1'b1;
            end else begin
              op_q        <= cmd_op;
              len_q       <= PTR_W'(cmd_len);
              wr_ptr_q    <= '0;
              rd_ptr_q    <= '0;
              cmd_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (load_last) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= iss_word[31:16];
              out_psum_q  <= pass0_psum;
              out_mode_q  <= pass0_mode;
              rd_ptr_q    <= PTR_W'(1);
              state_q     <= S_PASS0;
            end
          end
        end

        S_PASS0: begin
          if (!pass_end) begin
            out_valid_q <= 1'b1;
            out_data_q  <= iss_word[31:16];
            out_psum_q  <= pass0_psum;
            out_mode_q  <= pass0_mode;
            rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
          end else if (op_q == OP_SOFTMAX && DRAIN_CYC == 0) begin
            out_valid_q <= 1'b1;
            out_data_q  <= iss_word[31:16];
            out_psum_q  <= '0;
            out_mode_q  <= MODE_DIV;
            rd_ptr_q    <= PTR_W'(1);
            state_q     <= S_PASS1;
          end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_psum_q  <= '0;
            out_mode_q  <= '0;
            if (op_q == OP_SOFTMAX) begin
              drain_q <= '0;
              state_q <= S_DRAIN;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DRAIN: begin
          if (drain_q == DCW'(DRAIN_CYC - 1)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= iss_word[31:16];
            out_psum_q  <= '0;
            out_mode_q  <= MODE_DIV;
            rd_ptr_q    <= PTR_W'(1);
            state_q     <= S_PASS1;
          end else begin
            drain_q <= drain_q + DCW'(1);
          end
        end

        S_PASS1: begin
          if (!pass_end) begin
            out_valid_q <= 1'b1;
            out_data_q  <= iss_word[31:16];
            out_psum_q  <= '0;
            out_mode_q  <= MODE_DIV;
            rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
          end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_psum_q  <= '0;
            out_mode_q  <= '0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          cmd_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_psum_q  <= '0;
          out_mode_q  <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_psum  = out_psum_q;
  assign out_mode  = out_mode_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef ARITH_ISSUE_PERF_EN
  logic [31:0] perf_q;

  // Count every cycle that carries an issued beat; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (out_valid_q) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_arith_issue_seq.sv
// Scoreboard bench for arith_issue_seq: driver pushes expected beats/done/err with cycle stamps,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_arith_issue_seq;

  localparam int DEPTH = 8;
  localparam int DRAIN = 4;
`ifdef ARITH_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [15:0] in_psum = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] out_psum;
  logic [1:0]  out_mode;
  logic        done;
  logic        err;
  logic [31:0] perf_cnt;

  arith_issue_seq #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_psum(in_psum),
    .out_valid(out_valid), .out_data(out_data), .out_psum(out_psum), .out_mode(out_mode),
    .done(done), .err(err), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [15:0] p;
    logic [1:0]  m;
  } beat_t;

  beat_t       beat_q[$];
  int          done_q[$];
  int          err_q[$];
  beat_t       mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          load_win = 1'b0;
  int          beats_total = 0;
  logic [15:0] dv[16];
  logic [15:0] pv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          mon_e = beat_q.pop_front();
          chk("beat_cycle", cyc, mon_e.cyc);
          chk("beat_data", 32'(out_data), 32'(mon_e.d));
          chk("beat_psum", 32'(out_psum), 32'(mon_e.p));
          chk("beat_mode", 32'(out_mode), 32'(mon_e.m));
        end
      end else begin
        chk("idle_outputs", {out_data, out_psum}, 32'd0);
        chk("idle_mode", 32'(out_mode), 32'd0);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", 32'(err), 32'd0);
        else chk("err_cycle", cyc, err_q.pop_front());
      end
      if (!load_win) chk("in_ready_outside_load", 32'(in_ready), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bus", {out_data, out_psum}, 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_perf", perf_cnt, 32'd0);
    beat_q.delete();
    done_q.delete();
    err_q.delete();
    load_win    = 1'b0;
    beats_total = 0;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] len, output int acc);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      tick();
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    in_valid  = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    acc       = cyc;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 4'($urandom);
  endtask

  // Reference: beat i of pass 0 lands at L+1+i, pass 1 after len+DRAIN more cycles,
  // done the cycle after the final beat. abort_off>0 resets the DUT at cycle L+abort_off.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] len, input int gap_max,
                         input int abort_off);
    int    a;
    int    L;
    int    t;
    bit    aborted;
    beat_t b;
    aborted = 1'b0;
    L = 0;
    send_cmd(op, len, a);
    if (op == 2'd3 || len == 4'd0 || int'(len) > DEPTH) begin
      err_q.push_back(a + 1);
      chk("cmd_ready_after_illegal", 32'(cmd_ready), 32'd1);
      repeat (2) tick();
      return;
    end
    load_win = 1'b1;
    chk("in_ready_load_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(len); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_psum  = 16'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = dv[i];
      in_psum  = pv[i];
      L = cyc;
      chk("in_ready_beat", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    load_win = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      b.cyc = L + 1 + i;
      b.d   = dv[i];
      b.p   = (op == 2'd2) ? pv[i] : 16'd0;
      b.m   = (op == 2'd0) ? 2'd0 : (op == 2'd1) ? 2'd2 : 2'd3;
      beat_q.push_back(b);
    end
    if (op == 2'd0) begin
      for (int i = 0; i < int'(len); i++) begin
        b.cyc = L + 1 + int'(len) + DRAIN + i;
        b.d   = dv[i];
        b.p   = 16'd0;
        b.m   = 2'd1;
        beat_q.push_back(b);
      end
      done_q.push_back(L + 1 + 2 * int'(len) + DRAIN);
    end else begin
      done_q.push_back(L + 1 + int'(len));
    end
    t = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && t < 100) begin
      if (abort_off > 0 && cyc == L + abort_off) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      in_psum  = 16'($urandom);
      tick();
      t++;
    end
    in_valid = 1'b0;
    if (t >= 100) begin
      chk("completion_timeout", beat_q.size() + done_q.size(), 32'd0);
      beat_q.delete();
      done_q.delete();
    end
    tick();
    if (!aborted) begin
      beats_total += (op == 2'd0) ? 2 * int'(len) : int'(len);
      chk("perf_cnt", perf_cnt, PERF ? 32'(beats_total) : 32'd0);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) begin
      dv[i] = 16'($urandom);
      pv[i] = 16'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    chk("reset_out_valid_idle", 32'(out_valid), 32'd0);

    // Softmax len=3 with the reference vector.
    rand_data();
    dv[0] = 16'h3C00; dv[1] = 16'h4000; dv[2] = 16'h4200;
    run_cmd(2'd0, 4'd3, 0, 0);

    // GeLU full depth with input gaps.
    rand_data();
    run_cmd(2'd1, 4'd8, 3, 0);

    // AGG len=2 with psum pass-through.
    rand_data();
    dv[0] = 16'h3C00; pv[0] = 16'h4400;
    dv[1] = 16'h3800; pv[1] = 16'h4500;
    run_cmd(2'd2, 4'd2, 1, 0);

    // Illegal commands.
    run_cmd(2'd3, 4'd2, 0, 0);
    run_cmd(2'd0, 4'd9, 0, 0);
    run_cmd(2'd1, 4'd0, 0, 0);
    chk("idle_after_illegal", 32'(cmd_ready), 32'd1);

    // Reset in the middle of softmax pass 1, then a clean len=1 softmax.
    rand_data();
    run_cmd(2'd0, 4'd3, 0, 9);
    rand_data();
    run_cmd(2'd0, 4'd1, 0, 0);

    // Counter scenario from a fresh reset.
    do_reset();
    rand_data();
    run_cmd(2'd0, 4'd3, 1, 0);
    rand_data();
    run_cmd(2'd1, 4'd2, 1, 0);
    chk("perf_softmax3_gelu2", perf_cnt, PERF ? 32'd8 : 32'd0);

    // Randomized mix, including occasional illegal commands.
    for (int n = 0; n < 30; n++) begin
      rand_data();
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)), 2, 0);
    end

    repeat (3) tick();
    chk("leftover_expectations", beat_q.size() + done_q.size() + err_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
